sdram_init_controller: RTL and testbench
========================================

# sdram_init_controller

Power-up sequencer that sits between the AHB-Lite front end and the SDRAM command FSM. After reset it waits a programmable number of HCLK cycles for SDRAM power and clock stabilisation. It then raises a start request once the SDRAM FSM reports ready, and holds the request until the FSM acknowledges it. After that one acknowledged request it stays idle until the next reset, so it never re-initialises on its own.

## Interface
- INIT_POWER_UP_DELAY_CYCLES, default 20000: power-up wait in HCLK cycles (200 µs at 100 MHz). Must be ≥ 0.
- HCLK  input  1  system clock; all logic on the rising edge.
- HRESET  input  1  reset. Synchronous and active-high.
- sdram_ready_i  input  1  SDRAM command FSM is idle and able to accept an init request.
- sdram_init_ack_i  input  1  SDRAM FSM has accepted the init request.
- init_start_o  output  1  init request, registered, level-held until acknowledged.

## Operation
- State machine, one-hot or binary, registered.
- States: POWER_UP, WAIT_READY, START, DONE.
- Internal down-counter init_timer, width $clog2(INIT_POWER_UP_DELAY_CYCLES+1) (minimum 1 bit).
- Reset values:
  - state = POWER_UP, init_timer = INIT_POWER_UP_DELAY_CYCLES, init_start_o = 0.
  - Internal done flag = 0.
- POWER_UP:
  - If init_timer ≠ 0, decrement by 1.
  - If init_timer = 0 and sdram_ready_i = 1, go to START and set init_start_o = 1.
  - If init_timer = 0 and sdram_ready_i = 0, go to WAIT_READY.
- WAIT_READY: when sdram_ready_i = 1, go to START and set init_start_o = 1.
- START:
  - init_start_o is held at 1.
  - When sdram_init_ack_i = 1, clear init_start_o, set the done flag and go to DONE.
  - Deassertion of sdram_ready_i in START is ignored; the request stays up.
- DONE:
  - Terminal state; init_start_o = 0 regardless of inputs.
  - Leaves only on HRESET.
- sdram_init_ack_i is ignored in every state except START.
- Counter never wraps; it saturates at 0.

## Timing
- Reset has priority over all other inputs on any edge, including reset asserted mid-countdown or while init_start_o = 1. Both clear on that edge.
- With sdram_ready_i held high from reset release, init_start_o rises on rising edge N+1 after the first non-reset edge (N = INIT_POWER_UP_DELAY_CYCLES).
- N = 0: init_start_o rises on the first edge after reset with ready high.
- Ready arriving late: init_start_o rises on the first edge at which ready is sampled high after countdown expiry, i.e. 1-cycle latency.
- Ready high before countdown ends: no request before expiry.
- Ack latency: init_start_o falls on the edge at which ack is sampled high in START. A 1-cycle ack pulse is sufficient.
- Ack already high when START is entered: request lasts exactly one cycle.
- No combinational input-to-output path.

## Structure
- Single module, no sub-module needed.
- State encoding localparams (ST_POWER_UP, ST_WAIT_READY, ST_START, ST_DONE) belong in the shared sdram_ctrl package so the SDRAM FSM and debug logic can decode them.
- The package also holds the default power-up delay constant.

## Test plan
- Normal init, N=10, ready=1 after 12 cycles: init_start_o=1 one edge later. Ack=1 gives init_start_o=0 next edge, and it stays 0 for 2 more cycles.
- No re-init: after DONE, toggle ready 0→1 for 2 cycles with ack=0. init_start_o stays 0 throughout.
- Delayed ready after reset, N=10, ready=0 for 13 cycles: init_start_o=0. Then ready=1 gives init_start_o=1 next edge; ack gives 0 next edge.
- Early ready, N=10, ready=1 from cycle 0: init_start_o=0 for edges 1..10 and 1 at edge 11.
- Reset mid-operation: assert HRESET while init_start_o=1. Next edge init_start_o=0, the countdown restarts from N, and a full sequence succeeds again.
- Edge case N=0 with ack held high: init_start_o pulses high for exactly one cycle, then stays 0.

Source files
------------

// File: rtl/sdram_init_controller_pkg.sv
// Shared SDRAM control definitions: init sequencer state encodings and the power-up delay.
// The SDRAM command FSM and debug logic import this to decode the sequencer state.
package sdram_init_controller_pkg;

    localparam logic [1:0] ST_POWER_UP   = 2'd0;
    localparam logic [1:0] ST_WAIT_READY = 2'd1;
    localparam logic [1:0] ST_START      = 2'd2;
    localparam logic [1:0] ST_DONE       = 2'd3;

    // 200 us at a 100 MHz HCLK
    localparam int unsigned DEFAULT_INIT_POWER_UP_DELAY_CYCLES = 20000;

    // A zero delay still needs a 1-bit timer register.
    function automatic int timer_width(input int unsigned delay_cycles);
        return (delay_cycles == 0) ? 1 : $clog2(delay_cycles + 1);
    endfunction

endpackage

// File: rtl/sdram_init_controller_if.sv
// Init handshake between the power-up sequencer (master) and the SDRAM command FSM (slave).
interface sdram_init_controller_if;

    logic sdram_ready_i;
    logic sdram_init_ack_i;
    logic init_start_o;

    modport master (
        input  sdram_ready_i,
        input  sdram_init_ack_i,
        output init_start_o
    );

    modport slave (
        output sdram_ready_i,
        output sdram_init_ack_i,
        input  init_start_o
    );

endinterface

// File: rtl/sdram_init_controller.sv
// SDRAM power-up sequencer: waits out the power-up delay, then issues one init request
// to the SDRAM FSM and holds it until acknowledged. Never re-initialises before reset.
module sdram_init_controller
    import sdram_init_controller_pkg::*;
#(
    parameter int unsigned INIT_POWER_UP_DELAY_CYCLES = DEFAULT_INIT_POWER_UP_DELAY_CYCLES
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    sdram_init_controller_if.master sdram_if
);

    localparam int TIMER_W = timer_width(INIT_POWER_UP_DELAY_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(INIT_POWER_UP_DELAY_CYCLES);

    logic [1:0]         state_q, state_d;
    logic [TIMER_W-1:0] init_timer_q, init_timer_d;
    logic               init_start_q, init_start_d;
    logic               done_q, done_d;

    always_comb begin
        state_d      = state_q;
        init_timer_d = init_timer_q;
        init_start_d = init_start_q;
        done_d       = done_q;

        case (state_q)
            ST_POWER_UP: begin
                if (init_timer_q != '0) begin
                    init_timer_d = init_timer_q - TIMER_W'(1);
                end else if (sdram_if.sdram_ready_i) begin
                    state_d      = ST_START;
                    init_start_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                if (sdram_if.sdram_ready_i) begin
                    state_d      = ST_START;
                    init_start_d = 1'b1;
                end
            end
            ST_START: begin
                // Ready dropping here is ignored: the request stays up until acked.
                init_start_d = 1'b1;
                if (sdram_if.sdram_init_ack_i) begin
                    state_d      = ST_DONE;
                    init_start_d = 1'b0;
                    done_d       = 1'b1;
                end
            end
            ST_DONE: begin
                init_start_d = 1'b0;
            end
            default: begin
                state_d      = ST_POWER_UP;
                init_start_d = 1'b0;
            end
        endcase

        // Once initialised, stay terminal even if the state register were disturbed.
        if (done_q) begin
            state_d      = ST_DONE;
            init_start_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= ST_POWER_UP;
            init_timer_q <= TIMER_INIT;
            init_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_timer_q <= init_timer_d;
            init_start_q <= init_start_d;
            done_q       <= done_d;
        end
    end

    assign sdram_if.init_start_o = init_start_q;

endmodule

// File: tb/tb_sdram_init_controller.sv
// Directed bench for the SDRAM init sequencer: one instance with a 10-cycle delay, one with none.
module tb_sdram_init_controller;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    sdram_init_controller_if if10 ();
    sdram_init_controller_if if0 ();

    sdram_init_controller #(.INIT_POWER_UP_DELAY_CYCLES(10)) dut10 (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .sdram_if (if10.master)
    );

    sdram_init_controller #(.INIT_POWER_UP_DELAY_CYCLES(0)) dut0 (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .sdram_if (if0.master)
    );

    always #5 HCLK = ~HCLK;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic apply_reset();
        HRESET = 1'b1;
        tick();
        tick();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        if10.sdram_ready_i = 1'b1; if10.sdram_init_ack_i = 1'b0;
        if0.sdram_ready_i  = 1'b1; if0.sdram_init_ack_i  = 1'b0;
        HRESET = 1'b1;
        tick();
        checks++;
        if (if10.init_start_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_n10: init_start_o=%b expected 0", if10.init_start_o);
        end
        checks++;
        if (if0.init_start_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_n0: init_start_o=%b expected 0", if0.init_start_o);
        end
        if0.sdram_ready_i = 1'b0;
    endtask

    task automatic test_normal();
        if10.sdram_ready_i = 1'b0; if10.sdram_init_ack_i = 1'b0;
        apply_reset();
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (if10.init_start_o !== 1'b0) begin
                fails++;
                $display("FAIL normal_wait edge %0d: init_start_o=%b expected 0", e, if10.init_start_o);
            end
        end
        if10.sdram_ready_i = 1'b1;
        tick();
        checks++;
        if (if10.init_start_o !== 1'b1) begin
            fails++;
            $display("FAIL normal_start: init_start_o=%b expected 1", if10.init_start_o);
        end
        if10.sdram_init_ack_i = 1'b1;
        tick();
        if10.sdram_init_ack_i = 1'b0;
        checks++;
        if (if10.init_start_o !== 1'b0) begin
            fails++;
            $display("FAIL normal_ack: init_start_o=%b expected 0", if10.init_start_o);
        end
        for (int e = 0; e < 2; e++) begin
            tick();
            checks++;
            if (if10.init_start_o !== 1'b0) begin
                fails++;
                $display("FAIL normal_after_ack %0d: init_start_o=%b expected 0", e, if10.init_start_o);
            end
        end
    endtask

    task automatic test_no_reinit();
        if10.sdram_ready_i = 1'b0;
        tick();
        checks++;
        if (if10.init_start_o !== 1'b0) begin
            fails++;
            $display("FAIL no_reinit_low: init_start_o=%b expected 0", if10.init_start_o);
        end
        if10.sdram_ready_i = 1'b1;
        for (int e = 0; e < 2; e++) begin
            tick();
            checks++;
            if (if10.init_start_o !== 1'b0) begin
                fails++;
                $display("FAIL no_reinit_high %0d: init_start_o=%b expected 0", e, if10.init_start_o);
            end
        end
    endtask

    task automatic test_delayed_ready();
        if10.sdram_ready_i = 1'b0; if10.sdram_init_ack_i = 1'b0;
        apply_reset();
        for (int e = 1; e <= 13; e++) begin
            // A stray ack before START must not advance the sequencer.
            if10.sdram_init_ack_i = (e >= 11);
            tick();
            checks++;
            if (if10.init_start_o !== 1'b0) begin
                fails++;
                $display("FAIL delayed_wait edge %0d: init_start_o=%b expected 0", e, if10.init_start_o);
            end
        end
        if10.sdram_init_ack_i = 1'b0;
        if10.sdram_ready_i = 1'b1;
        tick();
        checks++;
        if (if10.init_start_o !== 1'b1) begin
            fails++;
            $display("FAIL delayed_start: init_start_o=%b expected 1", if10.init_start_o);
        end
        if10.sdram_ready_i = 1'b0;
        for (int e = 0; e < 2; e++) begin
            tick();
            checks++;
            if (if10.init_start_o !== 1'b1) begin
                fails++;
                $display("FAIL delayed_ready_drop %0d: init_start_o=%b expected 1", e, if10.init_start_o);
            end
        end
        if10.sdram_init_ack_i = 1'b1;
        tick();
        if10.sdram_init_ack_i = 1'b0;
        checks++;
        if (if10.init_start_o !== 1'b0) begin
            fails++;
            $display("FAIL delayed_ack: init_start_o=%b expected 0", if10.init_start_o);
        end
    endtask

    task automatic test_early_ready();
        if10.sdram_ready_i = 1'b1; if10.sdram_init_ack_i = 1'b0;
        apply_reset();
        for (int e = 1; e <= 11; e++) begin
            tick();
            checks++;
            if (if10.init_start_o !== (e == 11)) begin
                fails++;
                $display("FAIL early_ready edge %0d: init_start_o=%b expected %0d", e, if10.init_start_o, (e == 11));
            end
        end
        if10.sdram_init_ack_i = 1'b1;
        tick();
        if10.sdram_init_ack_i = 1'b0;
        checks++;
        if (if10.init_start_o !== 1'b0) begin
            fails++;
            $display("FAIL early_ack: init_start_o=%b expected 0", if10.init_start_o);
        end
    endtask

    task automatic test_reset_mid();
        if10.sdram_ready_i = 1'b1; if10.sdram_init_ack_i = 1'b0;
        apply_reset();
        for (int e = 1; e <= 11; e++) tick();
        checks++;
        if (if10.init_start_o !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pre: init_start_o=%b expected 1", if10.init_start_o);
        end
        HRESET = 1'b1;
        tick();
        checks++;
        if (if10.init_start_o !== 1'b0) begin
            fails++;
            $display("FAIL midreset_clear: init_start_o=%b expected 0", if10.init_start_o);
        end
        HRESET = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            tick();
            checks++;
            if (if10.init_start_o !== (e == 11)) begin
                fails++;
                $display("FAIL midreset_restart edge %0d: init_start_o=%b expected %0d", e, if10.init_start_o, (e == 11));
            end
        end
        if10.sdram_init_ack_i = 1'b1;
        tick();
        if10.sdram_init_ack_i = 1'b0;
        checks++;
        if (if10.init_start_o !== 1'b0) begin
            fails++;
            $display("FAIL midreset_ack: init_start_o=%b expected 0", if10.init_start_o);
        end
    endtask

    task automatic test_n0_ack_held();
        if0.sdram_ready_i = 1'b1; if0.sdram_init_ack_i = 1'b1;
        HRESET = 1'b1;
        tick();
        checks++;
        if (if0.init_start_o !== 1'b0) begin
            fails++;
            $display("FAIL n0_in_reset: init_start_o=%b expected 0", if0.init_start_o);
        end
        HRESET = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (if0.init_start_o !== (e == 1)) begin
                fails++;
                $display("FAIL n0_pulse edge %0d: init_start_o=%b expected %0d", e, if0.init_start_o, (e == 1));
            end
        end
        if0.sdram_ready_i = 1'b0; if0.sdram_init_ack_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_no_reinit();
        test_delayed_ready();
        test_early_ready();
        test_reset_mid();
        test_n0_ack_held();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
